// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time programmable pattern of 1..PAT_W bits.
// Supports overlapping or non-overlapping matches and keeps a saturating match counter.
module seq_detector_param #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StRun  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e             r_state,   w_state_d;
  logic [PAT_W-1:0]   r_pattern, w_pattern_d;
  logic [PAT_W-1:0]   r_hist,    w_hist_d;
  logic [LEN_W-1:0]   r_len,     w_len_d;
  logic [LEN_W-1:0]   r_fill,    w_fill_d;
  logic               r_overlap, w_overlap_d;
  logic               r_match,   w_match_d;
  logic [CNT_W-1:0]   r_count,   w_count_d;
  logic               r_cfg_err, w_cfg_err_d;

  logic               w_cfg_valid;
  logic               w_accept;
  logic [PAT_W:0]     w_hist_ext;
  logic [PAT_W-1:0]   w_hist_shift;
  logic [PAT_W:0]     w_len_mask;
  logic [LEN_W-1:0]   w_fill_inc;
  logic               w_full;
  logic               w_hit;

  // State register (with datapath registers); reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pattern <= '0;
      r_hist    <= '0;
      r_len     <= '0;
      r_fill    <= '0;
      r_overlap <= 1'b0;
      r_match   <= 1'b0;
      r_count   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pattern <= w_pattern_d;
      r_hist    <= w_hist_d;
      r_len     <= w_len_d;
      r_fill    <= w_fill_d;
      r_overlap <= w_overlap_d;
      r_match   <= w_match_d;
      r_count   <= w_count_d;
      r_cfg_err <= w_cfg_err_d;
    end
  end

  assign w_cfg_valid  = (cfg_len != '0) && (cfg_len <= MaxLen);
  // A load in the same cycle discards the incoming bit.
  assign w_accept     = in_valid && (r_state != StIdle) && !cfg_load;
  assign w_hist_ext   = {r_hist, in_bit};
  assign w_hist_shift = w_hist_ext[PAT_W-1:0];

  // Bit PAT_W of the extended history is always masked off (len <= PAT_W).
  always_comb begin
    w_len_mask = '0;
    for (int unsigned i = 0; i <= PAT_W; i++) begin
      w_len_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_fill_inc = (r_fill == r_len) ? r_fill : r_fill + LEN_W'(1);
  assign w_full     = (w_fill_inc == r_len);
  assign w_hit      = w_accept && w_full &&
                      (((w_hist_ext ^ {1'b0, r_pattern}) & w_len_mask) == '0);

  // Next-state logic.
  always_comb begin
    w_state_d   = r_state;
    w_pattern_d = r_pattern;
    w_hist_d    = r_hist;
    w_len_d     = r_len;
    w_fill_d    = r_fill;
    w_overlap_d = r_overlap;
    w_cfg_err_d = r_cfg_err;
    w_match_d   = w_hit;
    w_count_d   = r_count;

    if (cfg_load) begin
      w_hist_d = '0;
      w_fill_d = '0;
      if (w_cfg_valid) begin
        w_pattern_d = cfg_pattern;
        w_len_d     = cfg_len;
        w_overlap_d = cfg_overlap;
        w_cfg_err_d = 1'b0;
        w_state_d   = StFill;
      end else begin
        w_cfg_err_d = 1'b1;
        w_state_d   = StIdle;
      end
    end else if (w_accept) begin
      if (w_hit && !r_overlap) begin
        w_hist_d  = '0;
        w_fill_d  = '0;
        w_state_d = StFill;
      end else begin
        w_hist_d = w_hist_shift;
        w_fill_d = w_fill_inc;
        if (w_full) begin
          w_state_d = StRun;
        end
      end
    end

    if (clr_count) begin
      w_count_d = w_hit ? CNT_W'(1) : '0;
    end else if (w_hit && (r_count != CntMax)) begin
      w_count_d = r_count + CNT_W'(1);
    end
  end

  // Output logic.
  always_comb begin
    match       = r_match;
    match_count = r_count;
    state       = r_state;
    cfg_err     = r_cfg_err;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed vector table, saturation run,
// and randomized stimulus against a queue-based reference model.
module tb_seq_detector_param;

  localparam int PW   = 8;
  localparam int CW   = 8;
  localparam int LW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          cfg_load = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_overlap = 1'b0;
  logic          clr_count = 1'b0;
  logic          match;
  logic [CW-1:0] match_count;
  logic [1:0]    state;
  logic          cfg_err;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W(PW),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .clr_count  (clr_count),
    .match      (match),
    .match_count(match_count),
    .state      (state),
    .cfg_err    (cfg_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the accepted bits since the last history clear, kept as a queue.
  bit            m_cfg;
  logic [PW-1:0] m_pat;
  int            m_len;
  bit            m_ov;
  int            q[$];
  bit            m_match;
  int            m_count;
  bit            m_err;

  function automatic int m_state();
    if (!m_cfg) return 0;
    return (q.size() >= m_len) ? 2 : 1;
  endfunction

  task automatic model(bit r, bit ld, bit v, bit b, logic [PW-1:0] pat, int len, bit ov,
                       bit clr);
    bit hit;
    hit = 1'b0;
    if (r) begin
      m_cfg = 0; m_pat = '0; m_len = 0; m_ov = 0; q.delete();
      m_match = 0; m_count = 0; m_err = 0;
      return;
    end
    if (ld) begin
      q.delete();
      if (len >= 1 && len <= PW) begin
        m_cfg = 1; m_pat = pat; m_len = len; m_ov = ov; m_err = 0;
      end else begin
        m_cfg = 0; m_err = 1;
      end
    end else if (v && m_cfg) begin
      q.push_back(int'(b));
      if (q.size() > PW) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (q[q.size() - m_len + k] != int'(m_pat[m_len - 1 - k])) hit = 1'b0;
        end
      end
      if (hit && !m_ov) q.delete();
    end
    if (clr) m_count = hit ? 1 : 0;
    else if (hit && m_count < CMAX) m_count++;
    m_match = hit;
  endtask

  task automatic step(bit r, bit ld, bit v, bit b, logic [PW-1:0] pat, int len, bit ov,
                      bit clr, string tag);
    rst = r; cfg_load = ld; in_valid = v; in_bit = b;
    cfg_pattern = pat; cfg_len = LW'(len); cfg_overlap = ov; clr_count = clr;
    @(posedge clk);
    #1;
    model(r, ld, v, b, pat, len, ov, clr);
    check({tag, "_match"}, 32'(match), 32'(m_match));
    check({tag, "_count"}, 32'(match_count), 32'(m_count));
    check({tag, "_state"}, 32'(state), 32'(m_state()));
    check({tag, "_err"}, 32'(cfg_err), 32'(m_err));
  endtask

  typedef struct {
    bit            r, ld, v, b;
    logic [PW-1:0] pat;
    int            len;
    bit            ov, clr;
    bit            e_match;
    int            e_count;
    int            e_state;
    bit            e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic tv(bit r, bit ld, bit v, bit b, logic [PW-1:0] pat, int len, bit ov, bit clr,
                    bit em, int ec, int es, bit ee);
    vec_t t;
    t.r = r; t.ld = ld; t.v = v; t.b = b; t.pat = pat; t.len = len; t.ov = ov; t.clr = clr;
    t.e_match = em; t.e_count = ec; t.e_state = es; t.e_err = ee;
    tbl.push_back(t);
  endtask

  initial begin
    // Non-overlap 1001 on 1,0,0,1,0,0,1: single match on bit 4.
    tv(1,0,0,0,8'h00,0,0,0, 0,0,0,0);
    tv(0,1,0,0,8'h09,4,0,0, 0,0,1,0);
    tv(0,0,1,1,0,0,0,0, 0,0,1,0);
    tv(0,0,1,0,0,0,0,0, 0,0,1,0);
    tv(0,0,1,0,0,0,0,0, 0,0,1,0);
    tv(0,0,1,1,0,0,0,0, 1,1,1,0);
    tv(0,0,1,0,0,0,0,0, 0,1,1,0);
    tv(0,0,1,0,0,0,0,0, 0,1,1,0);
    tv(0,0,1,1,0,0,0,0, 0,1,1,0);
    // Same stream with overlap: matches on bits 4 and 7.
    tv(0,1,0,0,8'h09,4,1,0, 0,1,1,0);
    tv(0,0,1,1,0,0,0,0, 0,1,1,0);
    tv(0,0,1,0,0,0,0,0, 0,1,1,0);
    tv(0,0,1,0,0,0,0,0, 0,1,1,0);
    tv(0,0,1,1,0,0,0,0, 1,2,2,0);
    tv(0,0,1,0,0,0,0,0, 0,2,2,0);
    tv(0,0,1,0,0,0,0,0, 0,2,2,0);
    tv(0,0,1,1,0,0,0,0, 1,3,2,0);
    tv(0,0,0,0,0,0,0,1, 0,0,2,0);
    // 11 overlapping on 1,1,1,1: back-to-back matches.
    tv(0,1,0,0,8'h03,2,1,0, 0,0,1,0);
    tv(0,0,1,1,0,0,0,0, 0,0,1,0);
    tv(0,0,1,1,0,0,0,0, 1,1,2,0);
    tv(0,0,1,1,0,0,0,0, 1,2,2,0);
    tv(0,0,1,1,0,0,0,0, 1,3,2,0);
    // Invalid length, ignored bit in IDLE, then a valid len=1 load.
    tv(0,1,0,0,8'h03,0,1,0, 0,3,0,1);
    tv(0,0,1,1,0,0,0,0, 0,3,0,1);
    tv(0,1,0,0,8'h01,1,0,0, 0,3,1,0);
    tv(0,0,1,1,0,0,0,1, 1,1,1,0);
    tv(0,0,1,0,0,0,0,0, 0,1,2,0);
    tv(0,0,1,1,0,0,0,0, 1,2,1,0);
    // Partial 1,0,0 with gaps, load (with discarded bit), then 1 must not match.
    tv(0,1,0,0,8'h09,4,0,0, 0,2,1,0);
    tv(0,0,1,1,0,0,0,0, 0,2,1,0);
    tv(0,0,0,1,0,0,0,0, 0,2,1,0);
    tv(0,0,1,0,0,0,0,0, 0,2,1,0);
    tv(0,0,0,1,0,0,0,0, 0,2,1,0);
    tv(0,0,1,0,0,0,0,0, 0,2,1,0);
    tv(0,1,1,1,8'h09,4,0,0, 0,2,1,0);
    tv(0,0,1,1,0,0,0,0, 0,2,1,0);
    tv(0,0,1,0,0,0,0,0, 0,2,1,0);
    tv(0,0,1,0,0,0,0,0, 0,2,1,0);
    tv(0,0,1,1,0,0,0,0, 1,3,1,0);
    // Reset mid-RUN, then reset beating a simultaneous load.
    tv(0,1,0,0,8'h03,2,1,0, 0,3,1,0);
    tv(0,0,1,1,0,0,0,0, 0,3,1,0);
    tv(0,0,1,1,0,0,0,0, 1,4,2,0);
    tv(1,0,1,1,0,0,0,0, 0,0,0,0);
    tv(0,1,0,0,8'h03,9,0,0, 0,0,0,1);
    tv(1,1,1,1,8'h03,2,1,0, 0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].ld, tbl[i].v, tbl[i].b, tbl[i].pat, tbl[i].len, tbl[i].ov,
           tbl[i].clr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tmatch", i), 32'(match), 32'(tbl[i].e_match));
      check($sformatf("vec%0d_tcount", i), 32'(match_count), 32'(tbl[i].e_count));
      check($sformatf("vec%0d_tstate", i), 32'(state), 32'(tbl[i].e_state));
      check($sformatf("vec%0d_terr", i), 32'(cfg_err), 32'(tbl[i].e_err));
    end

    // Counter saturation with a len=1 pattern matching every bit.
    step(0,1,0,0,8'h01,1,1,0, "sat_load");
    for (int i = 0; i < CMAX + 5; i++) step(0,0,1,1,0,0,0,0, "sat");
    check("sat_count_hold", 32'(match_count), 32'(CMAX));
    check("sat_match_pulse", 32'(match), 32'd1);
    step(0,0,1,1,0,0,0,1, "sat_clr");
    check("sat_clr_to_one", 32'(match_count), 32'd1);

    // Randomized traffic against the model.
    step(1,0,0,0,0,0,0,0, "rnd_rst");
    for (int i = 0; i < 4000; i++) begin
      bit            r, ld, v, b, ov, clr;
      logic [PW-1:0] pat;
      int            len;
      r   = ($urandom_range(0, 499) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom);
      ov  = 1'($urandom);
      clr = ($urandom_range(0, 99) == 0);
      pat = PW'($urandom);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(1, 4));
      step(r, ld, v, b, pat, len, ov, clr, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed 4-bit, 4-pattern serial sequence detector.
- Detects a run-time programmable bit pattern of 1..PAT_W bits on a serial input. Supports overlapping or non-overlapping detection and input qualification.
- Counts matches with a saturating counter. Sits on the serial data path and feeds match pulses/counts to status logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of match counter.
- LEN_W, $clog2(PAT_W+1), width of cfg_len (derived; not to be overridden).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  qualifies in_bit; no bit consumed when low
- in_bit  in  1  serial data bit
- cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap, clear history
- cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is first bit in time, bit 0 last
- cfg_len  in  LEN_W  pattern length, valid range 1..PAT_W
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
- clr_count  in  1  clears match_count
- match  out  1  one-cycle pulse per detected pattern
- match_count  out  CNT_W  saturating count of matches
- state  out  2  FSM state: 0 IDLE, 1 FILL, 2 RUN
- cfg_err  out  1  last cfg_load carried invalid cfg_len

Behaviour:
- Reset values: match=0, match_count=0, state=IDLE, cfg_err=0. Internal pattern=0, len=0, overlap=0, history=0, fill count=0.
- Reset has priority over every other input.
- Internal history: PAT_W-bit shift register. On accepted bit (in_valid=1, state!=IDLE), history <= {history[PAT_W-2:0], in_bit}.
- Fill counter: counts accepted bits, saturates at len.
- FSM:
  - IDLE: bits ignored. cfg_load with 1<=cfg_len<=PAT_W -> FILL.
  - cfg_load with invalid cfg_len -> stays/enters IDLE, cfg_err=1.
  - FILL: accepted bits increment fill. Accepted bit making fill==len -> RUN, and is also compared that cycle (match possible on the len-th bit).
  - RUN: every accepted bit compared.
  - On match with overlap=0: history and fill cleared, -> FILL.
  - On match with overlap=1: stay in RUN.
  - cfg_load from FILL/RUN: history and fill cleared, -> FILL (or IDLE if invalid).
- Match condition: computed on the post-shift history; low len bits of new history equal low len bits of pattern. Bits above len ignored.
- Latency: match registered, asserted the cycle after the clock edge accepting the completing bit. Exactly one cycle wide; back-to-back pulses legal with overlap=1.
- cfg_err: set on invalid cfg_load, cleared on the next valid cfg_load or rst.
- match_count: +1 per match, saturates at 2^CNT_W-1, never wraps.
- Simultaneous events:
  - cfg_load and in_valid same cycle: load wins, bit discarded.
  - clr_count and a match in same cycle: match_count becomes 1.
  - in_valid=0 cycles: history, fill, state, count held; match=0.
  - cfg_load mid-pattern: partial history discarded; no match from old config after load edge.
- len=1: every accepted bit equal to pattern[0] matches; overlap setting is irrelevant.

Test Plan:
- rst, cfg_load pattern=8'h09 len=4 overlap=0, feed 1,0,0,1,0,0,1 -> one match, after 4th bit, count=1. Non-overlap prevents a second match.
- Same stream with overlap=1 -> matches after bits 4 and 7, count=2.
- pattern=8'h03 len=2 overlap=1, stream 1,1,1,1 -> matches after bits 2,3,4 back-to-back, count=3.
- CNT_W=2, pattern len=1 pattern=1, feed six 1s -> count 1,2,3,3,3,3 with match each cycle.
- Feed 1,0,0 with in_valid gaps, then cfg_load, then 1 -> no match; state returns to FILL, fill restarts.
- cfg_load len=0 -> state=IDLE, cfg_err=1. Then valid load -> cfg_err=0.
- clr_count coincident with a match -> count=1.
- rst asserted mid-RUN -> all outputs reset next cycle.
